// File: rtl/add_seq_arb_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer and its arbiter.
package add_seq_arb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/add_seq_arb_if.sv
// Bundle of requester, adder and result signals around add_seq_arb.
interface add_seq_arb_if #(
  parameter int WIDTH = 32
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both 1. A valid source holds its payload stable until that edge, and
  // valid never waits on ready. req_* is two lanes (bit i = requester i); res_* is one.
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       req_sub;
  logic [1:0]       req_last;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_g;
  logic             add_p;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_last;
  logic             res_cout;
  logic             res_ovf;
  logic             res_id;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_sub, req_last,
    input  add_s, add_g, add_p, res_ready,
    output req_ready, add_a, add_b, add_cin,
    output res_valid, res_sum, res_last, res_cout, res_ovf, res_id
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_sub, req_last,
    output add_s, add_g, add_p, res_ready,
    input  req_ready, add_a, add_b, add_cin,
    input  res_valid, res_sum, res_last, res_cout, res_ovf, res_id
  );

endinterface

// File: rtl/add_seq_arb_rr2.sv
// Two-way grant selector: round-robin on contention when fair_i, else requester 0 wins.
module arb_rr2
  import add_seq_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_winner_i,
  input  logic       fair_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = REQ0;
    if (valid_i == 2'b11) begin
      grant_o = fair_i ? ~last_winner_i : REQ0;
    end else if (valid_i[1]) begin
      grant_o = REQ1;
    end
  end

endmodule

// File: rtl/add_seq_arb.sv
// Packet sequencer in front of a shared adder: grants one requester per packet,
// chains carry word to word and returns a registered, id-tagged sum stream.
module add_seq_arb
  import add_seq_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit FAIR  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_arb_if.slave  bus,
  output state_e        dbg_state_o
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             first_q, first_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             last_winner_q, last_winner_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_last_q, res_last_d;
  logic             res_cout_q, res_cout_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_id_q, res_id_d;

  logic             grant;
  logic             own_valid;
  logic [WIDTH-1:0] own_a;
  logic [WIDTH-1:0] own_b;
  logic             own_sub;
  logic             own_last;
  logic             out_rdy;
  logic             drive;
  logic             accept;
  logic             sub_eff;
  logic [WIDTH-1:0] add_a_w;
  logic [WIDTH-1:0] add_b_w;
  logic             add_cin_w;
  logic             word_cout;
  logic             word_ovf;
  logic [1:0]       req_ready_w;

  arb_rr2 u_arb (
    .valid_i       (bus.req_valid),
    .last_winner_i (last_winner_q),
    .fair_i        (FAIR),
    .grant_o       (grant)
  );

  assign own_valid = bus.req_valid[owner_q];
  assign own_a     = owner_q ? bus.req_a1 : bus.req_a0;
  assign own_b     = owner_q ? bus.req_b1 : bus.req_b0;
  assign own_sub   = bus.req_sub[owner_q];
  assign own_last  = bus.req_last[owner_q];

  // The output register can take a new word when empty or being popped this cycle.
  assign out_rdy = ~res_valid_q | bus.res_ready;
  assign drive   = (state_q == ST_BUSY) & own_valid;
  assign accept  = drive & out_rdy;
  assign sub_eff = first_q ? own_sub : sub_q;

  always_comb begin
    add_a_w     = '0;
    add_b_w     = '0;
    add_cin_w   = 1'b0;
    req_ready_w = 2'b00;
    if (drive) begin
      add_a_w   = own_a;
      add_b_w   = sub_eff ? ~own_b : own_b;
      add_cin_w = first_q ? own_sub : carry_q;
    end
    if (state_q == ST_BUSY) begin
      req_ready_w[owner_q] = out_rdy;
    end
  end

  assign word_cout = bus.add_g | (bus.add_p & add_cin_w);
  assign word_ovf  = (add_a_w[MSB] == add_b_w[MSB]) & (bus.add_s[MSB] != add_a_w[MSB]);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    first_d       = first_q;
    sub_d         = sub_q;
    carry_d       = carry_q;
    last_winner_d = last_winner_q;
    res_valid_d   = res_valid_q & ~bus.res_ready;
    res_sum_d     = res_sum_q;
    res_last_d    = res_last_q;
    res_cout_d    = res_cout_q;
    res_ovf_d     = res_ovf_q;
    res_id_d      = res_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          owner_d = grant;
          first_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          res_valid_d = 1'b1;
          res_sum_d   = bus.add_s;
          res_cout_d  = word_cout;
          res_last_d  = own_last;
          res_ovf_d   = own_last & word_ovf;
          res_id_d    = owner_q;
          carry_d     = word_cout;
          sub_d       = sub_eff;
          first_d     = 1'b0;
          if (own_last) begin
            state_d       = ST_IDLE;
            last_winner_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= REQ0;
      first_q       <= 1'b0;
      sub_q         <= 1'b0;
      carry_q       <= 1'b0;
      last_winner_q <= REQ1;
      res_valid_q   <= 1'b0;
      res_sum_q     <= '0;
      res_last_q    <= 1'b0;
      res_cout_q    <= 1'b0;
      res_ovf_q     <= 1'b0;
      res_id_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      first_q       <= first_d;
      sub_q         <= sub_d;
      carry_q       <= carry_d;
      last_winner_q <= last_winner_d;
      res_valid_q   <= res_valid_d;
      res_sum_q     <= res_sum_d;
      res_last_q    <= res_last_d;
      res_cout_q    <= res_cout_d;
      res_ovf_q     <= res_ovf_d;
      res_id_q      <= res_id_d;
    end
  end

  assign bus.req_ready = req_ready_w;
  assign bus.add_a     = add_a_w;
  assign bus.add_b     = add_b_w;
  assign bus.add_cin   = add_cin_w;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_last  = res_last_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_id    = res_id_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_add_seq_arb.sv
// Bench for add_seq_arb: a round-robin instance driven by directed packets and a
// fixed-priority instance under contention, each with a behavioural adder.
module tb_add_seq_arb;
  import add_seq_arb_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_seq_arb_if #(.WIDTH(W)) bus ();
  add_seq_arb_if #(.WIDTH(W)) bus_fp ();
  state_e dbg_state;
  state_e dbg_state_fp;

  add_seq_arb #(.WIDTH(W), .FAIR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );
  add_seq_arb #(.WIDTH(W), .FAIR(1'b0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp), .dbg_state_o(dbg_state_fp)
  );

  // ---------------- stimulus signals ----------------
  logic         v0, v1, s0, s1, l0, l1, rr;
  logic [W-1:0] a0, b0, a1, b1;
  logic         fv0, fv1;
  logic [W-1:0] fa0, fa1;

  assign bus.req_valid = {v1, v0};
  assign bus.req_a0    = a0;
  assign bus.req_a1    = a1;
  assign bus.req_b0    = b0;
  assign bus.req_b1    = b1;
  assign bus.req_sub   = {s1, s0};
  assign bus.req_last  = {l1, l0};
  assign bus.res_ready = rr;

  assign bus_fp.req_valid = {fv1, fv0};
  assign bus_fp.req_a0    = fa0;
  assign bus_fp.req_a1    = fa1;
  assign bus_fp.req_b0    = '0;
  assign bus_fp.req_b1    = '0;
  assign bus_fp.req_sub   = 2'b00;
  assign bus_fp.req_last  = 2'b11;
  assign bus_fp.res_ready = 1'b1;

  // Behavioural stand-in for cla_32: group generate/propagate over the word.
  logic [W:0] gsum, gsum_fp;
  assign gsum         = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign bus.add_g    = gsum[W];
  assign bus.add_p    = &(bus.add_a ^ bus.add_b);
  assign bus.add_s    = bus.add_a + bus.add_b + {{(W-1){1'b0}}, bus.add_cin};
  assign gsum_fp      = {1'b0, bus_fp.add_a} + {1'b0, bus_fp.add_b};
  assign bus_fp.add_g = gsum_fp[W];
  assign bus_fp.add_p = &(bus_fp.add_a ^ bus_fp.add_b);
  assign bus_fp.add_s = bus_fp.add_a + bus_fp.add_b + {{(W-1){1'b0}}, bus_fp.add_cin};

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [W+3:0] exp_q[$];     // {id, last, cout, ovf, sum}
  logic [W-1:0] exp_fp_q[$];
  logic         fp_done = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  always @(negedge clk) begin : mon
    logic [W+3:0] e;
    if (rst_n && bus.res_valid && rr) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum 0x%08h, required no output", bus.res_sum);
      end else begin
        e = exp_q.pop_front();
        chk("res_sum",  bus.res_sum, e[W-1:0]);
        chk("res_ovf",  W'(bus.res_ovf), W'(e[W]));
        chk("res_cout", W'(bus.res_cout), W'(e[W+1]));
        chk("res_last", W'(bus.res_last), W'(e[W+2]));
        chk("res_id",   W'(bus.res_id), W'(e[W+3]));
      end
    end
  end

  always @(negedge clk) begin : mon_fp
    logic [W-1:0] e;
    if (rst_n && bus_fp.res_valid) begin
      if (exp_fp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fp_unexpected: got sum 0x%08h, required no output", bus_fp.res_sum);
      end else begin
        e = exp_fp_q.pop_front();
        chk("fp_order_sum", bus_fp.res_sum, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit sub, input bit last, input bit cin_exp,
                      input logic [W-1:0] sum_exp, input bit cout_exp, input bit ovf_exp,
                      input bit push);
    int n;
    n = 0;
    if (id == 1'b0) begin
      a0 = a; b0 = b; s0 = sub; l0 = last; v0 = 1'b1;
    end else begin
      a1 = a; b1 = b; s1 = sub; l1 = last; v1 = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[id] && n < 100);
    if (!bus.req_ready[id]) begin
      fail_now("send_timeout");
    end else begin
      chk("add_a", bus.add_a, a);
      chk("add_b", bus.add_b, sub ? ~b : b);
      chk("add_cin", W'(bus.add_cin), W'(cin_exp));
      @(posedge clk);
      #1;
      if (push) exp_q.push_back({id, last, cout_exp, ovf_exp, sum_exp});
    end
    if (id == 1'b0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  // ---------------- fixed-priority contention ----------------
  initial begin : fp_drv
    int k0, k1, n;
    logic acc0, acc1;
    k0 = 0; k1 = 0; n = 0;
    fv0 = 1'b0; fv1 = 1'b0; fa0 = '0; fa1 = '0;
    wait (rst_n === 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) exp_fp_q.push_back(W'(32'h10 + k));
    for (int k = 0; k < 3; k++) exp_fp_q.push_back(W'(32'h20 + k));
    fa0 = 32'h10; fa1 = 32'h20; fv0 = 1'b1; fv1 = 1'b1;
    while ((k0 < 3 || k1 < 3) && n < 200) begin
      @(negedge clk);
      n++;
      acc0 = fv0 & bus_fp.req_ready[0];
      acc1 = fv1 & bus_fp.req_ready[1];
      @(posedge clk);
      #1;
      if (acc0) begin k0++; fa0 = W'(32'h10 + k0); fv0 = (k0 < 3); end
      if (acc1) begin k1++; fa1 = W'(32'h20 + k1); fv1 = (k1 < 3); end
    end
    if (k0 < 3 || k1 < 3) fail_now("fp_timeout");
    fp_done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; l0 = 0; l1 = 0; rr = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", W'(bus.req_ready), W'(2'b00));
    chk("rst_res_valid", W'(bus.res_valid), '0);
    chk("rst_res_sum",   bus.res_sum, '0);
    chk("rst_res_flags", W'({bus.res_last, bus.res_cout, bus.res_ovf, bus.res_id}), '0);
    chk("rst_state",     W'(dbg_state), W'(ST_IDLE));
    chk("rst_add_a",     bus.add_a, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two-word add on requester 0.
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send(1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    drain();
    // Single-word subtract with borrow, then signed overflow, on requester 1.
    send(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    drain();
    send(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    drain();

    // Round-robin contention: expected order pushed ahead of the traffic.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, W'(32'h110 + k)});
      exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, W'(32'h1FB + k)});
    end
    fork
      for (int k = 0; k < 3; k++)
        send(1'b0, W'(32'h100 + k), 32'h10, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
        send(1'b1, W'(32'h200 + k), 32'h5, 1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    join
    drain();

    // Backpressure in the middle of a 4-word packet.
    fork
      begin
        send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        send(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        send(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(bus.res_valid && bus.res_sum == 32'h1) && n < 100);
        if (n >= 100) fail_now("bp_wait");
        @(posedge clk);
        #1 rr = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_res_valid", W'(bus.res_valid), W'(1'b1));
          chk("bp_res_sum",   bus.res_sum, 32'h0);
          chk("bp_res_cout",  W'(bus.res_cout), W'(1'b1));
          chk("bp_res_last",  W'(bus.res_last), W'(1'b0));
          chk("bp_req_ready", W'(bus.req_ready), W'(2'b00));
        end
        @(posedge clk);
        #1 rr = 1'b1;
      end
    join
    drain();

    n = 0;
    while (!fp_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!fp_done) fail_now("fp_done_wait");
    repeat (3) @(negedge clk);
    chk("fp_queue_empty", W'(exp_fp_q.size()), '0);

    // Reset after word 1 of 3; the result in flight is dropped.
    send(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_res_valid", W'(bus.res_valid), '0);
    chk("mrst_res_sum",   bus.res_sum, '0);
    chk("mrst_res_flags", W'({bus.res_last, bus.res_cout, bus.res_ovf, bus.res_id}), '0);
    chk("mrst_req_ready", W'(bus.req_ready), W'(2'b00));
    chk("mrst_state",     W'(dbg_state), W'(ST_IDLE));
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b1, 32'h0000_0010, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0, 1'b1);
    drain();
    chk("queue_empty", W'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/add_seq_arb.md
Name: add_seq_arb

Overview:
- Multi-precision add/subtract sequencer and 2-way arbiter in front of one shared 32-bit carry-lookahead adder (cla_32, instantiated alongside this block).
- Two requesters stream operand words, least-significant first, with a last flag.
- The block grants one requester per packet, drives the adder a/b/c_in, and chains carry across cycles from the adder's g_out/p_out.
- It returns a registered sum stream with final carry and signed-overflow flags, tagged with the requester id.

Parameters:
- WIDTH, 32, operand word width; must equal the adder width.
- FAIR, 1, 1 = round-robin per packet; 0 = fixed priority to requester 0.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester word valid, bit i = requester i
- req_ready  output  2  per-requester word accept
- req_a0, req_a1  input  WIDTH  operand A word, requester 0 / 1
- req_b0, req_b1  input  WIDTH  operand B word, requester 0 / 1
- req_sub  input  2  1 = packet is A-B; sampled on the first word only
- req_last  input  2  marks the most-significant word of a packet
- add_a  output  WIDTH  to adder a
- add_b  output  WIDTH  to adder b (B, or ~B when subtracting)
- add_cin  output  1  to adder c_in
- add_s  input  WIDTH  adder sum
- add_g  input  1  adder group generate
- add_p  input  1  adder group propagate
- res_valid  output  1  result word valid
- res_ready  input  1  downstream accept
- res_sum  output  WIDTH  result word
- res_last  output  1  last word of packet
- res_cout  output  1  carry out of the word; on the last word, 1 for subtraction means no borrow
- res_ovf  output  1  signed overflow; meaningful only when res_last = 1, else 0
- res_id  output  1  owning requester

Behaviour:
- Reset (async, rst_n = 0): state IDLE; req_ready = 0; res_valid = 0; res_sum = 0; res_last/res_cout/res_ovf/res_id = 0; carry register = 0; last_winner = 1, so requester 0 wins first.
- FSM, IDLE:
  - If any req_valid, latch owner and go to BUSY next cycle. No word is accepted in IDLE.
  - Both valid: FAIR = 1 picks the requester that is not last_winner; FAIR = 0 picks 0.
- FSM, BUSY:
  - req_ready[owner] = ~res_valid | res_ready. The non-owner's ready is 0.
  - A word is accepted when req_valid[owner] & req_ready[owner].
  - On the first word of the packet: sub flag = req_sub[owner] is latched, and add_cin = sub.
  - On later words: add_cin = carry register; req_sub is ignored.
  - Adder drive: add_a = A; add_b = sub ? ~B : B.
  - Word carry out = add_g | (add_p & add_cin).
  - On accept, register res_sum = add_s, res_cout = word carry, res_id = owner, res_last = req_last; res_valid goes to 1 next cycle. Carry register <= word carry.
  - Overflow on the last word: res_ovf = (add_a[MSB] == add_b[MSB]) & (add_s[MSB] != add_a[MSB]).
  - Accept with req_last = 1: go to IDLE, last_winner <= owner.
- Throughput and latency:
  - 1 word/cycle while res_ready stays high.
  - Latency: word accept -> res_valid 1 cycle. First req_valid in IDLE -> first accept 1 cycle later.
- add_a/add_b/add_cin are combinational from the owner's inputs. They are driven 0 in IDLE, and in BUSY whenever req_valid[owner] = 0.
- Output hold: while res_valid & ~res_ready, all res_* outputs hold and req_ready[owner] = 0.
- A res_ready pop and a new accept in the same cycle replace the output register with no bubble.
- Single-word packet (first word is also last): cin comes from sub, and cout/ovf apply to that word.
- The non-owner may hold req_valid for any length of time. It is granted at the next IDLE, with no starvation when FAIR = 1.
- Reset mid-packet: partial packet is abandoned, in-flight result dropped, all state returns to reset values.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE, ST_BUSY
  - WIDTH default
  - requester id constants REQ0, REQ1
- Natural sub-module: arb_rr2, a 2-way round-robin/fixed-priority grant selector.
  - Inputs: valid[1:0], last_winner, FAIR.
  - Outputs: grant id.
- Sequencer, carry chaining and output register stay in add_seq_arb.

Test Plan:
- Req0, 2 words, add:
  - Stimulus: A = {0x00000001, 0xFFFFFFFF}, B = {0x00000000, 0x00000001}.
  - Required: sums 0x00000000 (cout 1), then 0x00000002 (cout 0, last, ovf 0), id 0.
- Req1, 1 word, subtract:
  - Stimulus: 0x00000005 - 0x00000007.
  - Required: add_cin = 1, add_b = 0xFFFFFFF8, sum 0xFFFFFFFE, cout 0 (borrow), ovf 0.
- Signed overflow:
  - Stimulus: 1 word, 0x7FFFFFFF + 0x00000001.
  - Required: sum 0x80000000, ovf 1, cout 0.
- Contention with FAIR = 1:
  - Stimulus: both requesters hold 3 single-word packets.
  - Required: grants alternate 0,1,0,1,0,1. With FAIR = 0, all three of requester 0 are served first.
- Backpressure:
  - Stimulus: res_ready low for 4 cycles mid 4-word packet.
  - Required: res_* stable, req_ready low, no word lost or duplicated, carry chain correct after release.
- Mid-packet reset:
  - Stimulus: rst_n low for 1 cycle after word 1 of 3.
  - Required: res_valid = 0, outputs zero. Next packet from req1 gets cin from its own sub flag, not the stale carry.
